// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider for DIV/DIVU in the execute stage.
// Stalls the pipeline via pause and presents LO/HI with a one-cycle done.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        annul,
    output logic        pause,
    output logic        done,
    output logic [31:0] lo,
    output logic [31:0] hi,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ZERO,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [4:0]  cnt;
    logic [64:0] work;
    logic [31:0] dvsr;
    logic        q_neg;
    logic        r_neg;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [64:0] shifted;
    logic [32:0] trial;
    logic [64:0] work_step;
    logic [31:0] q_res;
    logic [31:0] r_res;
    logic        accept;

    assign a_neg = signed_div & dividend[31];
    assign b_neg = signed_div & divisor[31];
    assign a_abs = a_neg ? (~dividend + 32'd1) : dividend;
    assign b_abs = b_neg ? (~divisor + 32'd1) : divisor;

    // One restoring step: shift, trial-subtract, keep if non-negative
    assign shifted   = work << 1;
    assign trial     = shifted[64:32] - {1'b0, dvsr};
    assign work_step = trial[32] ? shifted
                                 : {trial, shifted[31:1], 1'b1};

    assign q_res = q_neg ? (~work_step[31:0] + 32'd1) : work_step[31:0];
    assign r_res = r_neg ? (~work_step[63:32] + 32'd1) : work_step[63:32];

    assign accept = start & ~annul;
    assign done   = (state == DONE);

    always_comb begin
        pause = 1'b0;
        unique case (state)
            IDLE:       pause = accept;
            BUSY, ZERO: pause = ~annul;
            default:    pause = 1'b0;
        endcase
        // Keep the stall request quiet while held in reset
        if (!rst) pause = 1'b0;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = (divisor == 32'd0) ? ZERO : BUSY;
            end
            BUSY: begin
                if (annul)              state_nx = IDLE;
                else if (cnt == 5'd31)  state_nx = DONE;
            end
            ZERO:    state_nx = annul ? IDLE : DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= 5'd0;
            work        <= 65'd0;
            dvsr        <= 32'd0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            lo          <= 32'd0;
            hi          <= 32'd0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        cnt <= 5'd0;
                        if (divisor == 32'd0) begin
                            work <= {33'd0, dividend};
                        end else begin
                            work  <= {33'd0, a_abs};
                            dvsr  <= b_abs;
                            q_neg <= a_neg ^ b_neg;
                            r_neg <= a_neg;
                        end
                    end
                end
                BUSY: begin
                    if (!annul) begin
                        work <= work_step;
                        cnt  <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            lo          <= q_res;
                            hi          <= r_res;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                ZERO: begin
                    if (!annul) begin
                        lo          <= 32'hFFFF_FFFF;
                        hi          <= work[31:0];
                        div_by_zero <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed divides with hand-computed results.
// A negedge monitor checks every done against the queued expectation.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        annul;
    logic        pause;
    logic        done;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc;
    int   n_chk;
    int   n_fail;

    div_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_div  (signed_div),
        .dividend    (dividend),
        .divisor     (divisor),
        .annul       (annul),
        .pause       (pause),
        .done        (done),
        .lo          (lo),
        .hi          (hi),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst && done) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("lo", lo, e.lo);
                chk("hi", hi, e.hi);
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic run_div(input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] elo,
                           input logic [31:0] ehi, input logic edbz,
                           input int lat, input logic hold);
        exp_t e;
        int   np;
        logic seen;
        @(posedge clk);
        #1;
        start      = 1'b1;
        signed_div = sgn;
        dividend   = a;
        divisor    = b;
        e.lo  = elo;
        e.hi  = ehi;
        e.dbz = edbz;
        e.cyc = cyc + lat;
        sbq.push_back(e);
        np   = 0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (pause) np++;
            if (done) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        chk("pause_len", np, lat);
        if (!hold) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst        = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        dividend   = 32'd0;
        divisor    = 32'd0;
        annul      = 1'b0;
        #3;
        chk("rst_pause", {31'd0, pause}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_hi", hi, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                1'b0, 33, 1'b0);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,
                1'b0, 33, 1'b0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,
                1'b0, 33, 1'b0);

        // Reset mid-BUSY with start still held
        @(posedge clk);
        #1;
        start      = 1'b1;
        signed_div = 1'b0;
        dividend   = 32'd100;
        divisor    = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_pause", {31'd0, pause}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        chk("midrst_pause_hold", {31'd0, pause}, 32'd0);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b0;

        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 1'b0);
        run_div(1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234,
                1'b1, 2, 1'b0);

        // Annul at cycle 5 of an in-flight divide
        @(posedge clk);
        #1;
        start      = 1'b1;
        signed_div = 1'b0;
        dividend   = 32'hFFFF_FFFF;
        divisor    = 32'd3;
        repeat (5) @(posedge clk);
        #1;
        annul = 1'b1;
        #1;
        chk("annul_pause", {31'd0, pause}, 32'd0);
        @(posedge clk);
        #1;
        annul = 1'b0;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("annul_idle_pause", {31'd0, pause}, 32'd0);
        chk("annul_lo_kept", lo, 32'hFFFF_FFFF);
        chk("annul_hi_kept", hi, 32'h1234);
        chk("annul_dbz_kept", {31'd0, div_by_zero}, 32'd1);

        // Back-to-back with start held through DONE
        run_div(1'b0, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 32'd0,
                1'b0, 33, 1'b1);
        run_div(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33, 1'b0);

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
